ahb_slave_arbiter_rr: RTL

AHB_SLAVE_ARBITER_RR -- requirements
Module: ahb_slave_arbiter_rr

---
 rtl/ahb_slave_arbiter_rr_if.sv | 17 +
 rtl/ahb_slave_arbiter_rr.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ahb_slave_arbiter_rr_if.sv
// Bus bundle between the requesting masters and the slave-port arbiter.
// The masters drive the request side and the arbiter drives the grant side.
interface ahb_slave_arbiter_rr_if #(
    parameter int MASTER_NUM = 4,
    parameter int IDX_W      = $clog2(MASTER_NUM)
) ();
    logic [MASTER_NUM-1:0]      hreq;
    logic [MASTER_NUM-1:0][2:0] hburst;
    logic                       hwait;
    logic [MASTER_NUM-1:0]      hgrant;
    logic                       hsel;
    logic [IDX_W-1:0]           hmaster;
    logic                       hlast;

    modport master (output hreq, hburst, hwait, input hgrant, hsel, hmaster, hlast);
    modport slave  (input hreq, hburst, hwait, output hgrant, hsel, hmaster, hlast);
endinterface

// File: rtl/ahb_slave_arbiter_rr.sv
// AHB slave-port arbiter: locks one owner for a whole burst, then re-arbitrates
// back-to-back using either fixed priority or round robin.
module ahb_slave_arbiter_rr #(
    parameter int MASTER_NUM = 4,
    parameter int ARB_MODE   = 1,
    parameter int IDX_W      = $clog2(MASTER_NUM)
) (
    input  logic                   hclk,
    input  logic                   hreset_n,
    ahb_slave_arbiter_rr_if.slave  bus
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_OWN     = 1'b1;
    localparam logic [2:0] BURST_INCR = 3'd1;

    logic [0:0]            state_r;
    logic [MASTER_NUM-1:0] grant_r;
    logic                  sel_r;
    logic [IDX_W-1:0]      master_r;
    logic [IDX_W-1:0]      last_owner_r;
    logic [2:0]            burst_r;
    logic [3:0]            count_r;

    logic                  win_found_s;
    logic [IDX_W-1:0]      win_idx_s;
    logic                  hlast_s;
    logic                  accept_s;
    logic                  end_s;
    logic                  load_s;

    // i-th candidate in search order; round robin starts just after the last owner
    function automatic logic [IDX_W-1:0] cand_idx(input logic [IDX_W-1:0] last, input int i);
        int c;
        c = (ARB_MODE == 0) ? i : ((int'(last) + 1 + i) % MASTER_NUM);
        return IDX_W'(c);
    endfunction

    // Count value of the final beat; INCR has no fixed length and uses hreq instead
    function automatic logic [3:0] beat_last_idx(input logic [2:0] burst);
        logic [3:0] r;
        case (burst)
            3'd0:    r = 4'd0;
            3'd2:    r = 4'd3;
            3'd3:    r = 4'd3;
            3'd4:    r = 4'd7;
            3'd5:    r = 4'd7;
            3'd6:    r = 4'd15;
            3'd7:    r = 4'd15;
            default: r = 4'd15;
        endcase
        return r;
    endfunction

    // Winner search over the current requests
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (!win_found_s && bus.hreq[cand_idx(last_owner_r, i)]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_idx(last_owner_r, i);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Final-beat flag of the current owner
    always_comb begin
        hlast_s = 1'b0;
        if (state_r == ST_OWN) begin
            if (burst_r == BURST_INCR) begin
                hlast_s = ~bus.hreq[master_r];
            end else begin
                hlast_s = (count_r == beat_last_idx(burst_r));
            end
        end else begin
            hlast_s = 1'b0;
        end
    end

    assign accept_s = sel_r & ~bus.hwait;
    assign end_s    = hlast_s & accept_s;
    assign load_s   = win_found_s & ((state_r == ST_IDLE) | end_s);

    // Ownership, grant and beat-count state
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            sel_r        <= 1'b0;
            master_r     <= '0;
            last_owner_r <= IDX_W'(MASTER_NUM - 1);
            burst_r      <= 3'd0;
            count_r      <= 4'd0;
        end else if (load_s) begin
            state_r      <= ST_OWN;
            grant_r      <= {{(MASTER_NUM-1){1'b0}}, 1'b1} << win_idx_s;
            sel_r        <= 1'b1;
            master_r     <= win_idx_s;
            last_owner_r <= win_idx_s;
            burst_r      <= bus.hburst[win_idx_s];
            count_r      <= 4'd0;
        end else if (end_s) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            sel_r        <= 1'b0;
            master_r     <= '0;
            count_r      <= 4'd0;
        end else if (accept_s) begin
            // Saturate so long INCR bursts never wrap back to zero
            if (count_r != 4'd15) begin
                count_r <= count_r + 4'd1;
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign bus.hgrant  = grant_r;
    assign bus.hsel    = sel_r;
    assign bus.hmaster = master_r;
    assign bus.hlast   = hlast_s;
endmodule
